// File: rtl/muldiv_sequencer_if.sv
// Handshake and HI/LO bus between the EX-stage control and the multiply/divide sequencer.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             rd_req;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, wr_hi, wr_lo, wdata, rd_req,
        input  busy, done, stall, hi, lo
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, wdata, rd_req,
        output busy, done, stall, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up in a final cycle.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic               clk,
    input  logic               rst,
    muldiv_sequencer_if.slave  bus
);
    localparam int CW = $clog2(ITER + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       op_r;
    logic             sa;
    logic             sb;
    logic             divzero;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] lowr;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             done_r;

    logic             in_signed;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             rem_ge;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] a_orig;

    assign in_signed = bus.op[0];
    assign mag_a = (in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b = (in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // acc holds the product high half (multiply) or the partial remainder (divide);
    // lowr holds the multiplier (multiply) or the dividend/quotient shift register (divide).
    assign mul_sum = {1'b0, acc} + (lowr[0] ? {1'b0, opnd_a} : '0);
    assign rem_sh  = {acc, lowr[WIDTH-1]};
    assign rem_ge  = rem_sh >= {1'b0, opnd_b};
    assign rem_sub = rem_sh[WIDTH-1:0] - opnd_b;

    assign prod     = {acc, lowr};
    assign prod_fix = (op_r[0] && (sa ^ sb)) ? -prod : prod;
    assign quo_fix  = (op_r[0] && (sa ^ sb)) ? -lowr : lowr;
    assign rem_fix  = (op_r[0] && sa) ? -acc : acc;
    // Original dividend rebuilt from magnitude and sign; sa is 0 for unsigned ops.
    assign a_orig   = sa ? -opnd_a : opnd_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_r    <= '0;
            sa      <= 1'b0;
            sb      <= 1'b0;
            divzero <= 1'b0;
            cnt     <= '0;
            opnd_a  <= '0;
            opnd_b  <= '0;
            acc     <= '0;
            lowr    <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_r    <= bus.op;
                        sa      <= in_signed & bus.a[WIDTH-1];
                        sb      <= in_signed & bus.b[WIDTH-1];
                        opnd_a  <= mag_a;
                        opnd_b  <= mag_b;
                        acc     <= '0;
                        lowr    <= bus.op[1] ? mag_a : mag_b;
                        cnt     <= '0;
                        divzero <= (bus.b == '0);
                        state   <= RUN;
                    end else begin
                        if (bus.wr_hi) hi_r <= bus.wdata;
                        if (bus.wr_lo) lo_r <= bus.wdata;
                    end
                end
                RUN: begin
                    if (op_r[1]) begin
                        acc  <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
                        lowr <= {lowr[WIDTH-2:0], rem_ge};
                    end else begin
                        acc  <= mul_sum[WIDTH:1];
                        lowr <= {mul_sum[0], lowr[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) state <= FIX;
                end
                FIX: begin
                    if (!op_r[1]) begin
                        hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix[WIDTH-1:0];
                    end else if (divzero) begin
                        hi_r <= a_orig;
                        lo_r <= '1;
                    end else begin
                        hi_r <= rem_fix;
                        lo_r <= quo_fix;
                    end
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = done_r;
    assign bus.stall = bus.rd_req & (state != IDLE);
    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer with hand-computed HI/LO results.
module tb_muldiv_sequencer;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32), .ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and follow it to the done cycle.
    task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                         input bit rq, input bit inject, input bit wr_with_start);
        int nb;
        int ns;
        bus.op    = o;
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        if (wr_with_start) begin
            bus.wr_lo = 1'b1;
            bus.wdata = 32'hDEADBEEF;
        end
        step();
        bus.start  = 1'b0;
        bus.wr_lo  = 1'b0;
        bus.rd_req = rq;
        #1;
        nb = 0;
        ns = 0;
        for (int i = 0; i < 40 && bus.busy; i++) begin
            nb++;
            if (bus.stall) ns++;
            if (i == 5) begin
                chk({name, "_hi_hold"}, bus.hi, cur_hi);
                chk({name, "_lo_hold"}, bus.lo, cur_lo);
            end
            if (inject && i == 10) begin
                bus.start = 1'b1;
                bus.wr_hi = 1'b1;
                bus.op    = 2'b00;
                bus.a     = 32'h11111111;
                bus.b     = 32'h2;
                bus.wdata = 32'hCAFEF00D;
            end
            if (inject && i == 11) begin
                bus.start = 1'b0;
                bus.wr_hi = 1'b0;
            end
            step();
        end
        chk({name, "_busy_cycles"}, 32'(nb), 32'd33);
        if (rq) chk({name, "_stall_cycles"}, 32'(ns), 32'd33);
        chk({name, "_done"}, 32'(bus.done), 32'd1);
        chk({name, "_stall_done"}, 32'(bus.stall), 32'd0);
        chk({name, "_hi"}, bus.hi, eh);
        chk({name, "_lo"}, bus.lo, el);
        bus.rd_req = 1'b0;
        step();
        chk({name, "_done_1cyc"}, 32'(bus.done), 32'd0);
        cur_hi = eh;
        cur_lo = el;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.a      = '0;
        bus.b      = '0;
        bus.wr_hi  = 1'b0;
        bus.wr_lo  = 1'b0;
        bus.wdata  = '0;
        bus.rd_req = 1'b0;
        step();
        step();
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        rst = 1'b0;
        step();

        bus.wr_hi = 1'b1;
        bus.wr_lo = 1'b1;
        bus.wdata = 32'h12345678;
        step();
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        chk("mthi", bus.hi, 32'h12345678);
        chk("mtlo", bus.lo, 32'h12345678);
        cur_hi = 32'h12345678;
        cur_lo = 32'h12345678;

        do_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 1'b1);
        do_op("mult_neg",  2'b01, 32'hFFFFFFF9, 32'd6,        32'hFFFFFFFF, 32'hFFFFFFD6, 1'b1, 1'b0, 1'b0);
        do_op("div_neg",   2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1, 1'b0);
        do_op("divu_zero", 2'b10, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        do_op("div_ovf",   2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 1'b0);
        do_op("div_zero",  2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        do_op("divu_7",    2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b0, 1'b0);

        // Abort a MULTU once the RUN counter has reached 10.
        bus.op    = 2'b00;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        #1;
        chk("abort_hi", bus.hi, 32'h0);
        chk("abort_lo", bus.lo, 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        step();
        rst = 1'b0;
        begin
            int nd;
            nd = 0;
            for (int i = 0; i < 40; i++) begin
                step();
                if (bus.done) nd++;
            end
            chk("abort_no_done", 32'(nd), 32'd0);
        end
        cur_hi = 32'h0;
        cur_lo = 32'h0;
        do_op("multu_3x5", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
